gpu_mode_sequencer: RTL and testbench

//  Parametrised PPU timing/mode controller: dot and line counters sequence OAM_READ -> VRAM_READ -> HBLANK per visible line, then VBLANK lines.

---
 rtl/gpu_mode_sequencer_pkg.sv | 49 ++++
 rtl/gpu_mode_sequencer_if.sv | 20 ++
 rtl/gpu_mode_sequencer_dot_line_counter.sv | 80 ++++++++
 rtl/gpu_mode_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_gpu_mode_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_mode_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// gpu_mode_sequencer_pkg
// Purpose : shared definitions for the PPU mode sequencer slice: the LCD mode
//           encodings, the CPU-visible register addresses, the LCDC/STAT bit
//           positions and the default scanline timing.
// Ports   : none (package).
// Config  : GPU_LYC_IRQ_EN is not referenced here; see gpu_mode_sequencer.sv.
// ---------------------------------------------------------------------------
package gpu_mode_sequencer_pkg;

    // LCD mode as reported in STAT[1:0] and on oMode.
    typedef enum logic [1:0] {
        HORIZONTAL_BLANK   = 2'd0,
        VERTICAL_BLANK     = 2'd1,
        SCANLINE_OAM_READ  = 2'd2,
        SCANLINE_VRAM_READ = 2'd3
    } gpu_mode_e;

    // CPU-visible register addresses.
    localparam logic [15:0] ADDR_LCDC = 16'hFF40;
    localparam logic [15:0] ADDR_STAT = 16'hFF41;
    localparam logic [15:0] ADDR_LY   = 16'hFF44;
    localparam logic [15:0] ADDR_LYC  = 16'hFF45;

    // LCDC bit that switches the display (and therefore the counters) on.
    localparam int LCDC_ENABLE_BIT = 7;

    // STAT interrupt-enable bit positions.
    localparam int STAT_HBLANK_IE = 3;
    localparam int STAT_VBLANK_IE = 4;
    localparam int STAT_OAM_IE    = 5;
    localparam int STAT_LYC_IE    = 6;

    // Default scanline timing of the real hardware.
    localparam int DEF_DOTS_PER_LINE = 456;
    localparam int DEF_OAM_DOTS      = 80;
    localparam int DEF_VRAM_DOTS     = 172;
    localparam int DEF_VISIBLE_LINES = 144;
    localparam int DEF_TOTAL_LINES   = 154;
    localparam int DEF_DOT_W         = 9;

    // STAT read layout: bit 7 is unimplemented and always reads 1.
    function automatic logic [7:0] packStat(input logic [3:0] enables,
                                            input logic       coincidence,
                                            input gpu_mode_e  mode);
        return {1'b1, enables, coincidence, mode};
    endfunction

endpackage

// File: rtl/gpu_mode_sequencer_if.sv
// ---------------------------------------------------------------------------
// gpu_mode_sequencer_if
// Purpose : CPU register bus into the mode sequencer.
// Signals : iAddr  16  CPU address
//           iWe     1  CPU write strobe
//           iData   8  CPU write data
//           oData   8  combinational read data
// Modports: master (CPU side drives address/strobe/data), slave (sequencer).
// ---------------------------------------------------------------------------
interface gpu_mode_sequencer_if;

    logic [15:0] iAddr;
    logic        iWe;
    logic [7:0]  iData;
    logic [7:0]  oData;

    modport master (output iAddr, output iWe, output iData, input oData);
    modport slave  (input iAddr, input iWe, input iData, output oData);

endinterface

// File: rtl/gpu_mode_sequencer_dot_line_counter.sv
// ---------------------------------------------------------------------------
// gpu_dot_line_counter
// Purpose : dot-within-line and line (LY) counters for the PPU. Exposes both
//           the current counter values and the values they take at the next
//           clock, so the sequencer can register its decoded outputs in the
//           same cycle as the counters.
// Ports   : iClock       clock
//           iReset       synchronous, active-high reset
//           i_enable     display enable as it will be after this clock
//           o_dot        current dot index
//           o_ly         current line
//           o_nextDot    dot index after this clock
//           o_nextLy     line after this clock
//           o_lineWrap   this clock wraps the dot counter to a new line
// ---------------------------------------------------------------------------
module gpu_dot_line_counter
    import gpu_mode_sequencer_pkg::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
    parameter int DOT_W         = DEF_DOT_W
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             i_enable,
    output logic [DOT_W-1:0] o_dot,
    output logic [7:0]       o_ly,
    output logic [DOT_W-1:0] o_nextDot,
    output logic [7:0]       o_nextLy,
    output logic             o_lineWrap
);

    localparam logic [DOT_W-1:0] LAST_DOT  = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [7:0]       LAST_LINE = 8'(TOTAL_LINES - 1);

    logic [DOT_W-1:0] r_dot;
    logic [7:0]       r_ly;
    logic             r_running;
    logic [DOT_W-1:0] w_nextDot;
    logic [7:0]       w_nextLy;
    logic             w_lineWrap;

    // Next counter values. While disabled the counters sit at dot 0 / line 0.
    // The first enabled clock after being off keeps them at 0 so the frame
    // starts cleanly at dot 0 of line 0; after that they advance every clock.
    always_comb begin
        w_nextDot  = '0;
        w_nextLy   = '0;
        w_lineWrap = 1'b0;
        if (i_enable && r_running) begin
            if (r_dot == LAST_DOT) begin
                w_lineWrap = 1'b1;
                w_nextLy   = (r_ly == LAST_LINE) ? 8'd0 : r_ly + 8'd1;
            end else begin
                w_nextDot = r_dot + DOT_W'(1);
                w_nextLy  = r_ly;
            end
        end
    end

    // Counter registers; r_running remembers whether we counted last clock.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_dot     <= '0;
            r_ly      <= '0;
            r_running <= 1'b0;
        end else begin
            r_dot     <= w_nextDot;
            r_ly      <= w_nextLy;
            r_running <= i_enable;
        end
    end

    assign o_dot      = r_dot;
    assign o_ly       = r_ly;
    assign o_nextDot  = w_nextDot;
    assign o_nextLy   = w_nextLy;
    assign o_lineWrap = w_lineWrap;

endmodule

// File: rtl/gpu_mode_sequencer.sv
// ---------------------------------------------------------------------------
// gpu_mode_sequencer
// Purpose : PPU timing/mode controller. Sequences OAM_READ -> VRAM_READ ->
//           HBLANK on each visible line followed by VBLANK lines, owns the
//           LCDC/STAT/LY/LYC registers and raises VBlank and STAT interrupt
//           pulses.
// Ports   : iClock       clock
//           iReset       synchronous, active-high reset
//           bus          CPU register bus (gpu_mode_sequencer_if.slave)
//           oMode        0=HBLANK 1=VBLANK 2=OAM_READ 3=VRAM_READ
//           oLY          current line
//           oDot         dot index within the line
//           oVBlankIrq   one-clock pulse on entering the first VBLANK line
//           oStatIrq     one-clock pulse on a rising edge of the STAT source
// Config  : GPU_LYC_IRQ_EN - when defined, STAT[2] reports LY==LYC and
//           STAT[6] enables it as a STAT interrupt source. Otherwise both
//           read 0 and LYC is plain storage.
// ---------------------------------------------------------------------------
module gpu_mode_sequencer
    import gpu_mode_sequencer_pkg::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int OAM_DOTS      = DEF_OAM_DOTS,
    parameter int VRAM_DOTS     = DEF_VRAM_DOTS,
    parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES,
    parameter int DOT_W         = DEF_DOT_W
) (
    input  logic                 iClock,
    input  logic                 iReset,
    gpu_mode_sequencer_if.slave  bus,
    output logic [1:0]           oMode,
    output logic [7:0]           oLY,
    output logic [DOT_W-1:0]     oDot,
    output logic                 oVBlankIrq,
    output logic                 oStatIrq
);

    localparam logic [DOT_W-1:0] VRAM_START  = DOT_W'(OAM_DOTS);
    localparam logic [DOT_W-1:0] HBLANK_START = DOT_W'(OAM_DOTS + VRAM_DOTS);
    localparam logic [7:0]       VBLANK_LINE = 8'(VISIBLE_LINES);

    logic [7:0]       r_lcdc;
    logic [6:3]       r_statEn;
    logic [7:0]       r_lyc;
    logic [7:0]       w_nextLcdc;
    logic [6:3]       w_nextStatEn;
    logic [7:0]       w_nextLyc;
    logic             w_enable;

    logic [DOT_W-1:0] w_dot;
    logic [7:0]       w_ly;
    logic [DOT_W-1:0] w_nextDot;
    logic [7:0]       w_nextLy;
    logic             w_lineWrap;

    gpu_mode_e        r_mode;
    gpu_mode_e        w_nextMode;

    logic             w_coincNext;
    logic             w_coincRead;
    logic             w_nextSource;
    logic             r_statSource;
    logic             r_statIrq;
    logic             r_vblankIrq;
    logic [7:0]       w_readData;

    // Register write decode. A write is folded into the "next" register values
    // so that everything decoded from them (display enable, STAT enables, LYC
    // coincidence) reacts on the same clock the write lands. LY is read-only,
    // so writes to it simply fall through.
    always_comb begin
        w_nextLcdc   = r_lcdc;
        w_nextStatEn = r_statEn;
        w_nextLyc    = r_lyc;
        if (bus.iWe) begin
            case (bus.iAddr)
                ADDR_LCDC: w_nextLcdc = bus.iData;
`ifdef GPU_LYC_IRQ_EN
                ADDR_STAT: w_nextStatEn = bus.iData[6:3];
`else
                ADDR_STAT: w_nextStatEn = {1'b0, bus.iData[5:3]};
`endif
                ADDR_LYC:  w_nextLyc = bus.iData;
                default:   ;
            endcase
        end
    end

    assign w_enable = w_nextLcdc[LCDC_ENABLE_BIT];

    gpu_dot_line_counter #(
        .DOTS_PER_LINE (DOTS_PER_LINE),
        .TOTAL_LINES   (TOTAL_LINES),
        .DOT_W         (DOT_W)
    ) u_counter (
        .iClock     (iClock),
        .iReset     (iReset),
        .i_enable   (w_enable),
        .o_dot      (w_dot),
        .o_ly       (w_ly),
        .o_nextDot  (w_nextDot),
        .o_nextLy   (w_nextLy),
        .o_lineWrap (w_lineWrap)
    );

    // Mode decode from the counter values of the next clock, so the registered
    // mode lines up with oDot/oLY. With the display off the mode rests in HBLANK.
    always_comb begin
        w_nextMode = HORIZONTAL_BLANK;
        if (w_enable) begin
            if (w_nextLy >= VBLANK_LINE) begin
                w_nextMode = VERTICAL_BLANK;
            end else if (w_nextDot < VRAM_START) begin
                w_nextMode = SCANLINE_OAM_READ;
            end else if (w_nextDot < HBLANK_START) begin
                w_nextMode = SCANLINE_VRAM_READ;
            end
        end
    end

    // Mode state register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_mode <= HORIZONTAL_BLANK;
        end else begin
            r_mode <= w_nextMode;
        end
    end

    // LY==LYC coincidence flag, tracked only in builds that expose it.
`ifdef GPU_LYC_IRQ_EN
    logic r_coinc;

    assign w_coincNext = (w_nextLy == w_nextLyc);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_coinc <= 1'b0;
        end else begin
            r_coinc <= w_coincNext;
        end
    end

    assign w_coincRead = r_coinc;
`else
    assign w_coincNext = 1'b0;
    assign w_coincRead = 1'b0;
`endif

    // STAT interrupt source as it will be after this clock. It is the OR of
    // all enabled conditions, so back-to-back conditions (OAM straight after
    // HBLANK, say) keep it high and do not raise a second pulse.
    assign w_nextSource = w_enable &
        ((w_nextStatEn[STAT_HBLANK_IE] & (w_nextMode == HORIZONTAL_BLANK))  |
         (w_nextStatEn[STAT_VBLANK_IE] & (w_nextMode == VERTICAL_BLANK))    |
         (w_nextStatEn[STAT_OAM_IE]    & (w_nextMode == SCANLINE_OAM_READ)) |
         (w_nextStatEn[STAT_LYC_IE]    & w_coincNext));

    // CPU registers and interrupt pulses. The STAT pulse fires when the source
    // rises; the VBlank pulse fires when the line counter wraps into the first
    // non-visible line, which is always at dot 0.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_lcdc       <= 8'h00;
            r_statEn     <= 4'h0;
            r_lyc        <= 8'h00;
            r_statSource <= 1'b0;
            r_statIrq    <= 1'b0;
            r_vblankIrq  <= 1'b0;
        end else begin
            r_lcdc       <= w_nextLcdc;
            r_statEn     <= w_nextStatEn;
            r_lyc        <= w_nextLyc;
            r_statSource <= w_nextSource;
            r_statIrq    <= w_nextSource & ~r_statSource;
            r_vblankIrq  <= w_lineWrap & (w_nextLy == VBLANK_LINE);
        end
    end

    // Combinational register read-back; unmapped addresses read 0.
    always_comb begin
        w_readData = 8'h00;
        case (bus.iAddr)
            ADDR_LCDC: w_readData = r_lcdc;
            ADDR_STAT: w_readData = packStat(r_statEn, w_coincRead, r_mode);
            ADDR_LY:   w_readData = w_ly;
            ADDR_LYC:  w_readData = r_lyc;
            default:   ;
        endcase
    end

    assign bus.oData  = w_readData;
    assign oMode      = r_mode;
    assign oLY        = w_ly;
    assign oDot       = w_dot;
    assign oVBlankIrq = r_vblankIrq;
    assign oStatIrq   = r_statIrq;

endmodule

// File: tb/tb_gpu_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gpu_mode_sequencer
// Purpose : self-checking bench for gpu_mode_sequencer, run with a shortened
//           frame so whole frames fit in a short run. The reference model
//           tracks the position in the frame as a single dot count and derives
//           dot, line, mode and interrupts from it arithmetically.
// Config  : follows GPU_LYC_IRQ_EN like the design.
// ---------------------------------------------------------------------------
module tb_gpu_mode_sequencer;

    localparam int DPL   = 40;
    localparam int OAM   = 8;
    localparam int VRAM  = 12;
    localparam int VIS   = 12;
    localparam int TOT   = 15;
    localparam int DW    = 6;
    localparam int FRAME = DPL * TOT;

`ifdef GPU_LYC_IRQ_EN
    localparam bit         LYC_EN    = 1'b1;
    localparam logic [7:0] STAT_MASK = 8'h78;
`else
    localparam bit         LYC_EN    = 1'b0;
    localparam logic [7:0] STAT_MASK = 8'h38;
`endif

    logic          iClock = 1'b0;
    logic          iReset = 1'b1;
    logic [1:0]    oMode;
    logic [7:0]    oLY;
    logic [DW-1:0] oDot;
    logic          oVBlankIrq;
    logic          oStatIrq;

    always #5 iClock = ~iClock;

    gpu_mode_sequencer_if busIf ();

    gpu_mode_sequencer #(
        .DOTS_PER_LINE (DPL),
        .OAM_DOTS      (OAM),
        .VRAM_DOTS     (VRAM),
        .VISIBLE_LINES (VIS),
        .TOTAL_LINES   (TOT),
        .DOT_W         (DW)
    ) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .bus        (busIf),
        .oMode      (oMode),
        .oLY        (oLY),
        .oDot       (oDot),
        .oVBlankIrq (oVBlankIrq),
        .oStatIrq   (oStatIrq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: register contents, display on flag, and the
    // dot position within the frame.
    logic [7:0] mLcdc = 8'h00;
    logic [7:0] mStat = 8'h00;
    logic [7:0] mLyc  = 8'h00;
    bit         mOn = 1'b0;
    int         mT = 0;
    bit         mCoinc = 1'b0;
    bit         mPrevSrc = 1'b0;
    bit         mVbl = 1'b0;
    bit         mStatIrq = 1'b0;

    logic [15:0] readAddrs [5] = '{16'hFF40, 16'hFF41, 16'hFF44, 16'hFF45, 16'h1234};

    function automatic int mDot();
        return mT % DPL;
    endfunction

    function automatic int mLy();
        return mT / DPL;
    endfunction

    function automatic int mMode();
        if (!mOn)              return 0;
        if (mLy() >= VIS)      return 1;
        if (mDot() < OAM)      return 2;
        if (mDot() < OAM+VRAM) return 3;
        return 0;
    endfunction

    function automatic logic [7:0] mRead(input logic [15:0] addr);
        case (addr)
            16'hFF40: return mLcdc;
            16'hFF41: return 8'h80 | mStat | (mCoinc ? 8'h04 : 8'h00) | 8'(mMode());
            16'hFF44: return 8'(mLy());
            16'hFF45: return mLyc;
            default:  return 8'h00;
        endcase
    endfunction

    // Advance the reference model by one clock edge with the given bus inputs.
    task automatic modelEdge(input logic we, input logic [15:0] addr, input logic [7:0] data);
        bit src;
        int md;
        if (iReset) begin
            mLcdc = 8'h00; mStat = 8'h00; mLyc = 8'h00;
            mOn = 1'b0; mT = 0; mCoinc = 1'b0;
            mPrevSrc = 1'b0; mVbl = 1'b0; mStatIrq = 1'b0;
        end else begin
            if (we) begin
                case (addr)
                    16'hFF40: mLcdc = data;
                    16'hFF41: mStat = data & STAT_MASK;
                    16'hFF45: mLyc = data;
                    default:  ;
                endcase
            end
            if (mLcdc[7]) begin
                mT  = mOn ? (mT + 1) % FRAME : 0;
                mOn = 1'b1;
            end else begin
                mOn = 1'b0;
                mT  = 0;
            end
            mVbl   = mOn && (mT == VIS * DPL);
            mCoinc = LYC_EN && (mLy() == int'(mLyc));
            md     = mMode();
            src    = mOn && ((mStat[3] && md == 0) || (mStat[4] && md == 1) ||
                             (mStat[5] && md == 2) || (mStat[6] && mCoinc));
            mStatIrq = src && !mPrevSrc;
            mPrevSrc = src;
        end
    endtask

    // One comparison: counts it, and reports and counts a failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one clock of bus activity: check the combinational read for the
    // driven address, clock, then check every registered output.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] data);
        busIf.iWe   = we;
        busIf.iAddr = addr;
        busIf.iData = data;
        #1;
        checkOutput("readData", 32'(busIf.oData), 32'(mRead(addr)));
        @(posedge iClock);
        modelEdge(we, addr, data);
        #1;
        checkOutput("dot",      32'(oDot),       32'(mDot()));
        checkOutput("ly",       32'(oLY),        32'(mLy()));
        checkOutput("mode",     32'(oMode),      32'(mMode()));
        checkOutput("vblankIrq", 32'(oVBlankIrq), 32'(mVbl));
        checkOutput("statIrq",  32'(oStatIrq),   32'(mStatIrq));
        busIf.iWe = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, readAddrs[i % 5], 8'h00);
    endtask

    task automatic runCount(input int n, output int vb, output int st);
        vb = 0;
        st = 0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, readAddrs[i % 5], 8'h00);
            if (oVBlankIrq === 1'b1) vb++;
            if (oStatIrq === 1'b1) st++;
        end
    endtask

    task automatic readReg(input logic [15:0] addr, input logic [7:0] expected, input string tag);
        busIf.iAddr = addr;
        #1;
        checkOutput(tag, 32'(busIf.oData), 32'(expected));
    endtask

    initial begin
        int vb;
        int st;
        int r;
        logic [7:0] d;

        busIf.iWe   = 1'b0;
        busIf.iAddr = 16'h0000;
        busIf.iData = 8'h00;
        iReset      = 1'b1;
        @(posedge iClock);
        #1;

        // Reset values.
        applyStimulus(1'b0, 16'h0000, 8'h00);
        checkOutput("resetMode", 32'(oMode), 32'd0);
        checkOutput("resetLY", 32'(oLY), 32'd0);
        readReg(16'h0000, 8'h00, "resetData");
        iReset = 1'b0;

        // LY is read-only; STAT with the display off.
        applyStimulus(1'b1, 16'hFF44, 8'h55);
        readReg(16'hFF44, 8'h00, "lyWriteIgnored");
        busIf.iAddr = 16'hFF41;
        #1;
        checkOutput("statOffBits", 32'({busIf.oData[7], busIf.oData[1:0]}), 32'(3'b100));

        // Enable and walk one line's mode boundaries.
        applyStimulus(1'b1, 16'hFF40, 8'h80);
        checkOutput("enDot", 32'(oDot), 32'd0);
        checkOutput("enMode", 32'(oMode), 32'd2);
        idle(8);
        checkOutput("vramDot", 32'(oDot), 32'd8);
        checkOutput("vramMode", 32'(oMode), 32'd3);
        idle(12);
        checkOutput("hblankMode", 32'(oMode), 32'd0);
        idle(19);
        checkOutput("lastDot", 32'(oDot), 32'(DPL - 1));
        idle(1);
        checkOutput("line1LY", 32'(oLY), 32'd1);
        checkOutput("line1Mode", 32'(oMode), 32'd2);

        // One full frame: exactly one VBlank pulse, no STAT pulses.
        runCount(FRAME, vb, st);
        checkOutput("vblankPerFrame", 32'(vb), 32'd1);
        checkOutput("statNoneEnabled", 32'(st), 32'd0);

        // Last VBLANK line wraps back to line 0 in OAM_READ.
        idle(FRAME - 1 - DPL);
        checkOutput("lastLineLY", 32'(oLY), 32'(TOT - 1));
        checkOutput("lastLineMode", 32'(oMode), 32'd1);
        idle(1);
        checkOutput("wrapLY", 32'(oLY), 32'd0);
        checkOutput("wrapMode", 32'(oMode), 32'd2);

        // HBLANK STAT source: one pulse per visible line.
        applyStimulus(1'b1, 16'hFF41, 8'h08);
        runCount(FRAME - 1, vb, st);
        checkOutput("hblankStatPulses", 32'(st), 32'(VIS));
        checkOutput("hblankFrameVbl", 32'(vb), 32'd1);

        // LY==LYC source.
        applyStimulus(1'b1, 16'hFF45, 8'd10);
        applyStimulus(1'b1, 16'hFF41, 8'h40);
        idle(10 * DPL - 2);
        checkOutput("lycLY", 32'(oLY), 32'd10);
        checkOutput("lycPulse", 32'(oStatIrq), 32'(LYC_EN));
        busIf.iAddr = 16'hFF41;
        #1;
        checkOutput("lycCoincOn", 32'(busIf.oData[2]), 32'(LYC_EN));
        idle(1);
        checkOutput("lycPulseDone", 32'(oStatIrq), 32'd0);
        idle(DPL - 1);
        busIf.iAddr = 16'hFF41;
        #1;
        checkOutput("lycCoincOff", 32'(busIf.oData[2]), 32'd0);
        runCount(FRAME, vb, st);
        checkOutput("lycPulsesPerFrame", 32'(st), 32'(LYC_EN));

        // Display off mid-line, then back on.
        idle(5 * DPL + 10 - 440 + FRAME);
        checkOutput("midLineLY", 32'(oLY), 32'd5);
        applyStimulus(1'b1, 16'hFF40, 8'h00);
        checkOutput("offLY", 32'(oLY), 32'd0);
        checkOutput("offMode", 32'(oMode), 32'd0);
        readReg(16'hFF44, 8'h00, "offReadLY");
        applyStimulus(1'b1, 16'hFF40, 8'h80);
        checkOutput("reEnMode", 32'(oMode), 32'd2);
        checkOutput("reEnLY", 32'(oLY), 32'd0);

        // Reset mid-frame.
        idle(100);
        iReset = 1'b1;
        applyStimulus(1'b0, 16'hFF40, 8'h00);
        checkOutput("midResetDot", 32'(oDot), 32'd0);
        checkOutput("midResetMode", 32'(oMode), 32'd0);
        iReset = 1'b0;
        readReg(16'hFF40, 8'h00, "midResetLcdc");

        // Randomised register traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                d = 8'($urandom_range(0, 255));
                d = ($urandom_range(0, 3) == 0) ? (d & 8'h7F) : (d | 8'h80);
                applyStimulus(1'b1, 16'hFF40, d);
            end else if (r < 10) begin
                applyStimulus(1'b1, 16'hFF41, 8'($urandom_range(0, 255)));
            end else if (r < 14) begin
                applyStimulus(1'b1, 16'hFF45, 8'($urandom_range(0, TOT - 1)));
            end else if (r < 16) begin
                applyStimulus(1'b1, 16'hFF44, 8'($urandom_range(0, 255)));
            end else if (r < 17) begin
                iReset = 1'b1;
                applyStimulus(1'b0, 16'h0000, 8'h00);
                iReset = 1'b0;
            end else if (r < 19) begin
                applyStimulus(1'b0, 16'($urandom_range(0, 65535)), 8'h00);
            end else begin
                applyStimulus(1'b0, readAddrs[$urandom_range(0, 3)], 8'h00);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
